// File: rtl/stream_dword_serializer.sv
// Word-to-byte stream serializer: accepts 32-bit words holding 1-4 valid bytes and emits
// them one byte per cycle, with a 2-entry word FIFO so word-rate sources see no bubbles.
module stream_dword_serializer #(
  parameter bit          MSB_FIRST = 1'b0,
  parameter int unsigned COUNT_W   = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  // Word input
  input  logic               s_valid_i,
  output logic               s_ready_o,
  input  logic [31:0]        s_data_i,
  input  logic [1:0]         s_bytes_i,
  // Byte output
  output logic               m_valid_o,
  input  logic               m_ready_i,
  output logic [7:0]         m_data_o,
  output logic               m_last_o,
  // Status
  output logic [COUNT_W-1:0] byte_count_o,
  output logic               busy_o
);

  typedef enum logic [0:0] {StIdle, StActive} state_e;

  state_e state_q, state_d;

  // Output shift stage
  logic [31:0] word_q, word_d;
  logic [1:0]  len_q, len_d;
  logic [1:0]  idx_q, idx_d;

  // Pending-word FIFO
  logic [31:0] fifo_data_q [2];
  logic [1:0]  fifo_len_q  [2];
  logic        rd_ptr_q, rd_ptr_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic [1:0]  cnt_q, cnt_d;

  logic               s_ready_q, s_ready_d;
  logic [COUNT_W-1:0] byte_count_q, byte_count_d;

  logic        in_xfer;
  logic        out_xfer;
  logic        is_last;
  logic        fifo_empty;
  logic        load_head;
  logic        load_in;
  logic        push;
  logic        pop;
  logic [31:0] word_shift;
  logic [7:0]  byte_sel;

  assign in_xfer    = s_valid_i & s_ready_q;
  assign out_xfer   = (state_q == StActive) & m_ready_i;
  assign is_last    = (idx_q == len_q);
  assign fifo_empty = (cnt_q == 2'd0);

  // Next-state logic for the shift stage; the FIFO head always wins over a bypassing word.
  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    len_d     = len_q;
    idx_d     = idx_q;
    load_head = 1'b0;
    load_in   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          load_head = 1'b1;
        end else if (in_xfer) begin
          load_in = 1'b1;
        end
      end
      StActive: begin
        if (out_xfer) begin
          if (!is_last) begin
            idx_d = idx_q + 2'd1;
          end else if (!fifo_empty) begin
            load_head = 1'b1;
          end else if (in_xfer) begin
            load_in = 1'b1;
          end else begin
            state_d = StIdle;
            idx_d   = 2'd0;
          end
        end
      end
      default: begin
        state_d = StIdle;
        idx_d   = 2'd0;
      end
    endcase

    if (load_head) begin
      state_d = StActive;
      word_d  = fifo_data_q[rd_ptr_q];
      len_d   = fifo_len_q[rd_ptr_q];
      idx_d   = 2'd0;
    end else if (load_in) begin
      state_d = StActive;
      word_d  = s_data_i;
      len_d   = s_bytes_i;
      idx_d   = 2'd0;
    end
  end

  // FIFO bookkeeping; a bypassing word never touches the FIFO.
  always_comb begin
    push     = in_xfer & ~load_in;
    pop      = load_head;
    wr_ptr_d = push ? ~wr_ptr_q : wr_ptr_q;
    rd_ptr_d = pop ? ~rd_ptr_q : rd_ptr_q;
    cnt_d    = cnt_q + {1'b0, push} - {1'b0, pop};
    // s_ready is registered, so it reflects occupancy after this edge.
    s_ready_d = (cnt_d < 2'd2);
  end

  always_comb begin
    byte_count_d = byte_count_q;
    if (out_xfer) begin
      byte_count_d = byte_count_q + {{(COUNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      word_q       <= 32'h0;
      len_q        <= 2'd0;
      idx_q        <= 2'd0;
      rd_ptr_q     <= 1'b0;
      wr_ptr_q     <= 1'b0;
      cnt_q        <= 2'd0;
      s_ready_q    <= 1'b0;
      byte_count_q <= '0;
    end else begin
      state_q      <= state_d;
      word_q       <= word_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      cnt_q        <= cnt_d;
      s_ready_q    <= s_ready_d;
      byte_count_q <= byte_count_d;
    end
  end

  // FIFO storage needs no reset: occupancy gates every read.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= s_data_i;
      fifo_len_q[wr_ptr_q]  <= s_bytes_i;
    end
  end

  // Shift the selected byte into a fixed lane.
  always_comb begin
    if (MSB_FIRST) begin
      word_shift = word_q << {idx_q, 3'b000};
      byte_sel   = word_shift[31:24];
    end else begin
      word_shift = word_q >> {idx_q, 3'b000};
      byte_sel   = word_shift[7:0];
    end
  end

  assign m_valid_o    = (state_q == StActive);
  assign m_data_o     = m_valid_o ? byte_sel : 8'h00;
  assign m_last_o     = m_valid_o & is_last;
  assign s_ready_o    = s_ready_q;
  assign byte_count_o = byte_count_q;
  assign busy_o       = m_valid_o | ~fifo_empty;

endmodule

// File: tb/tb_stream_dword_serializer.sv
// Bench for stream_dword_serializer: an LSB-first/16-bit-count instance and an
// MSB-first/4-bit-count instance share stimulus and are checked against a byte-queue model.
module tb_stream_dword_serializer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic [31:0] s_data = 32'h0;
  logic [1:0]  s_bytes = 2'd0;
  logic        m_ready = 1'b1;

  logic        m_valid0, m_last0, s_ready0, busy0;
  logic [7:0]  m_data0;
  logic [15:0] byte_count0;
  logic        m_valid1, m_last1, s_ready1, busy1;
  logic [7:0]  m_data1;
  logic [3:0]  byte_count1;

  always #5 clk = ~clk;

  stream_dword_serializer #(
    .MSB_FIRST (1'b0),
    .COUNT_W   (16)
  ) u_dut_lsb (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .s_valid_i    (s_valid),
    .s_ready_o    (s_ready0),
    .s_data_i     (s_data),
    .s_bytes_i    (s_bytes),
    .m_valid_o    (m_valid0),
    .m_ready_i    (m_ready),
    .m_data_o     (m_data0),
    .m_last_o     (m_last0),
    .byte_count_o (byte_count0),
    .busy_o       (busy0)
  );

  stream_dword_serializer #(
    .MSB_FIRST (1'b1),
    .COUNT_W   (4)
  ) u_dut_msb (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .s_valid_i    (s_valid),
    .s_ready_o    (s_ready1),
    .s_data_i     (s_data),
    .s_bytes_i    (s_bytes),
    .m_valid_o    (m_valid1),
    .m_ready_i    (m_ready),
    .m_data_o     (m_data1),
    .m_last_o     (m_last1),
    .byte_count_o (byte_count1),
    .busy_o       (busy1)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Model: words in flight, bytes still to emit ({last, data}), bytes transferred so far.
  int          words = 0;
  int unsigned nbytes = 0;
  bit          exp_s_ready = 1'b0;
  logic [8:0]  q_lsb[$];
  logic [8:0]  q_msb[$];

  int hold_n = 0;
  bit rand_ready = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_push(input logic [31:0] d, input logic [1:0] b);
    for (int i = 0; i <= int'(b); i++) begin
      q_lsb.push_back({(i == int'(b)), d[8*i +: 8]});
      q_msb.push_back({(i == int'(b)), d[8*(3-i) +: 8]});
    end
  endtask

  task automatic check_outputs();
    check("m_valid0", {31'h0, m_valid0}, {31'h0, words > 0});
    check("m_valid1", {31'h0, m_valid1}, {31'h0, words > 0});
    check("s_ready0", {31'h0, s_ready0}, {31'h0, exp_s_ready});
    check("s_ready1", {31'h0, s_ready1}, {31'h0, exp_s_ready});
    check("busy0", {31'h0, busy0}, {31'h0, words > 0});
    check("busy1", {31'h0, busy1}, {31'h0, words > 0});
    check("count0", {16'h0, byte_count0}, nbytes % 65536);
    check("count1", {28'h0, byte_count1}, nbytes % 16);
    if (words > 0) begin
      check("data0", {24'h0, m_data0}, {24'h0, q_lsb[0][7:0]});
      check("last0", {31'h0, m_last0}, {31'h0, q_lsb[0][8]});
      check("data1", {24'h0, m_data1}, {24'h0, q_msb[0][7:0]});
      check("last1", {31'h0, m_last1}, {31'h0, q_msb[0][8]});
    end
  endtask

  // One clock: set m_ready, predict transfers, advance the model, check at the falling edge.
  task automatic cycle(output bit in_x);
    bit         out_x;
    logic [8:0] b;
    if (hold_n > 0) begin
      m_ready = 1'b0;
      hold_n--;
    end else if (rand_ready) begin
      m_ready = ($urandom_range(0, 3) != 0);
    end else begin
      m_ready = 1'b1;
    end
    in_x  = s_valid && exp_s_ready;
    out_x = (words > 0) && m_ready;
    @(posedge clk);
    if (out_x) begin
      b = q_lsb.pop_front();
      void'(q_msb.pop_front());
      if (b[8]) words--;
      nbytes++;
    end
    if (in_x) begin
      model_push(s_data, s_bytes);
      words++;
    end
    exp_s_ready = (words <= 2);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic tick();
    bit dummy;
    cycle(dummy);
  endtask

  task automatic send_word(input logic [31:0] d, input logic [1:0] b, input bit keep);
    bit acc = 1'b0;
    int n = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_bytes = b;
    while (!acc && n < 200) begin
      cycle(acc);
      n++;
    end
    if (!acc) check("send_timeout", 32'd0, 32'd1);
    if (!keep) begin
      s_valid = 1'b0;
      s_data  = $urandom;
      s_bytes = 2'($urandom_range(0, 3));
    end
  endtask

  task automatic drain();
    int n = 0;
    s_valid = 1'b0;
    while (words > 0 && n < 400) begin
      tick();
      n++;
    end
    if (words > 0) check("drain_timeout", words, 32'd0);
  endtask

  // Assert reset off-edge, check outputs clear at once, release on a falling edge.
  task automatic do_reset();
    #2;
    rst_n   = 1'b0;
    s_valid = 1'b0;
    hold_n  = 0;
    words   = 0;
    nbytes  = 0;
    exp_s_ready = 1'b0;
    q_lsb.delete();
    q_msb.delete();
    #1;
    check("rst_m_valid", {31'h0, m_valid0}, 32'd0);
    check("rst_m_data", {24'h0, m_data0}, 32'd0);
    check("rst_m_last", {31'h0, m_last0}, 32'd0);
    check("rst_s_ready", {31'h0, s_ready0}, 32'd0);
    check("rst_count", {16'h0, byte_count0}, 32'd0);
    check("rst_busy", {31'h0, busy0}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bit keep;

    // Single 4-byte word
    do_reset();
    send_word(32'hDDCCBBAA, 2'd3, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check("single_data", {24'h0, m_data0}, 32'hAA + 32'h11 * i);
      check("single_last", {31'h0, m_last0}, {31'h0, i == 3});
      tick();
    end
    check("single_count", {16'h0, byte_count0}, 32'd4);
    check("single_busy", {31'h0, busy0}, 32'd0);

    // Partial word, both byte orders
    do_reset();
    send_word(32'h44332211, 2'd1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      check("part_lsb", {24'h0, m_data0}, 32'h11 * (i + 1));
      check("part_msb", {24'h0, m_data1}, 32'h44 - 32'h11 * i);
      check("part_last", {31'h0, m_last0}, {31'h0, i == 1});
      tick();
    end
    check("part_idle", {31'h0, m_valid0}, 32'd0);
    check("part_count", {16'h0, byte_count0}, 32'd2);

    // Backpressure while BB is presented
    do_reset();
    send_word(32'hDDCCBBAA, 2'd3, 1'b0);
    tick();
    hold_n = 3;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_data", {24'h0, m_data0}, 32'hBB);
      check("bp_valid", {31'h0, m_valid0}, 32'd1);
      check("bp_last", {31'h0, m_last0}, 32'd0);
    end
    drain();
    check("bp_count", {16'h0, byte_count0}, 32'd4);

    // Back-to-back with output stalled for the first 8 cycles
    do_reset();
    hold_n = 8;
    send_word(32'h13121110, 2'd3, 1'b1);
    send_word(32'h23222120, 2'd3, 1'b1);
    send_word(32'h33323130, 2'd3, 1'b0);
    check("b2b_sready_low", {31'h0, s_ready0}, 32'd0);
    drain();
    check("b2b_count", {16'h0, byte_count0}, 32'd12);

    // Reset during byte 2 of 4, then a fresh word
    do_reset();
    send_word(32'hDDCCBBAA, 2'd3, 1'b0);
    tick();
    check("mid_byte2", {24'h0, m_data0}, 32'hBB);
    do_reset();
    tick();
    tick();
    check("mid_no_stale", {31'h0, m_valid0}, 32'd0);
    send_word(32'h87654321, 2'd3, 1'b0);
    drain();
    check("mid_count", {16'h0, byte_count0}, 32'd4);

    // 4-bit counter wrap: 20 bytes reads back as 4
    do_reset();
    for (int w = 0; w < 5; w++) send_word($urandom, 2'd3, 1'b0);
    drain();
    check("wrap_count", {28'h0, byte_count1}, 32'd4);

    // Randomized traffic with random backpressure and input gaps
    do_reset();
    rand_ready = 1'b1;
    for (int w = 0; w < 250; w++) begin
      if (!s_valid) begin
        for (int g = $urandom_range(0, 2); g > 0; g--) tick();
      end
      keep = (w != 249) && ($urandom_range(0, 1) == 1);
      send_word($urandom, 2'($urandom_range(0, 3)), keep);
    end
    drain();
    rand_ready = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/stream_dword_serializer.md
# stream_dword_serializer

Upstream feeder for the byte-wide stream input of the sample design under test. Accepts 32-bit words carrying 1–4 valid bytes over a valid/ready handshake and emits them one byte per cycle on a valid/ready byte stream. The byte stream's m_valid/m_data drive the DUT's stream_in_valid/stream_in_data. m_ready is driven by the DUT's ready. Contains a 2-entry word FIFO so word-rate sources stream without bubbles.

## Interface
- MSB_FIRST, 0, 0: byte 0 = s_data[7:0] emitted first; 1: s_data[31:24] emitted first.
- COUNT_W, 16, width of byte_count.
- clk  in  1  sole clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset; asserts immediately, released synchronously by the user.
- s_valid  in  1  input word valid.
- s_ready  out  1  input word ready (registered).
- s_data  in  32  input word.
- s_bytes  in  2  number of valid bytes minus 1 (0 = 1 byte, 3 = 4 bytes); sampled with s_data.
- m_valid  out  1  output byte valid.
- m_ready  in  1  output byte ready.
- m_data  out  8  output byte.
- m_last  out  1  high with the final byte of each word.
- byte_count  out  COUNT_W  total bytes transferred on m_*, wraps modulo 2^COUNT_W.
- busy  out  1  high when the FIFO is non-empty or m_valid is high.

## Operation
- Input transfer: s_valid && s_ready at a rising edge. Output transfer: m_valid && m_ready at a rising edge.
- Storage: the active word sits in an output shift stage with byte index idx (0..len) and length len. Pending words wait in a 2-entry FIFO holding {data, len}.
- s_ready is registered: next value = (FIFO occupancy after this edge < 2). A pop and a push in the same cycle is legal. When s_ready=0, the word is not taken even if a pop occurs that edge.
- FSM states:
  - IDLE: m_valid=0.
  - ACTIVE: m_valid=1.
- IDLE -> ACTIVE:
  - On an input transfer with an empty FIFO, the word bypasses the FIFO into the shift stage with idx=0.
  - Alternatively, if the FIFO is non-empty, the FIFO head loads.
- ACTIVE, output transfer with idx<len: idx increments and m_data advances to the next byte.
- ACTIVE, output transfer with idx==len (m_last=1):
  - If the FIFO is non-empty, the head loads into the shift stage.
  - Otherwise, if an input transfer occurs the same edge, that word loads directly.
  - In either load case the FSM stays ACTIVE with idx=0, giving no bubble between words.
  - With no word available, go to IDLE.
- Byte selection:
  - MSB_FIRST=0: byte idx is s_data[8*idx+7 -: 8].
  - MSB_FIRST=1: byte idx is s_data[31-8*idx -: 8].
  - Bytes above len are never emitted.
- m_last = ACTIVE && idx==len.
- Backpressure: while m_valid && !m_ready, m_data, m_last and idx hold stable.
- byte_count increments by 1 per output transfer and wraps from all-ones to 0.
- busy = m_valid || FIFO non-empty.

## Timing
- Reset values while reset_n low:
  - m_valid=0, m_data=8'h00, m_last=0, s_ready=0, byte_count=0, busy=0.
  - FIFO empty, FSM IDLE, idx=0.
- s_ready rises at the first rising edge after reset_n deasserts.
- Latency: a word accepted at edge N while idle presents its first byte (m_valid=1) in the cycle after edge N.
- Throughput: 1 byte/cycle when m_ready is held high. Consecutive words have no idle cycle between m_last and the next word's first byte.
- Reset asserted mid-word: all outputs go to their reset values asynchronously. Partial words and FIFO contents are discarded. Nothing resumes after release.
- s_data/s_bytes may change freely when s_valid=0. Per protocol they are held while s_valid && !s_ready; the block does not check this.

## Test plan
- Single 4-byte word: s_data=32'hDDCCBBAA, s_bytes=3, MSB_FIRST=0, m_ready=1.
  - Expect m_data AA,BB,CC,DD on 4 consecutive cycles, m_last only with DD.
  - Expect byte_count=4 and busy low afterwards.
- Partial word: s_data=32'h44332211, s_bytes=1.
  - Expect bytes 11,22 with m_last on 22; bytes 33/44 are never emitted.
  - Repeat with MSB_FIRST=1: expect 44,33.
- Backpressure: one 4-byte word, m_ready dropped for 3 cycles while byte BB is presented.
  - Expect m_data=BB, m_valid=1, m_last=0 stable for those cycles, then CC,DD after m_ready returns.
  - Expect byte_count=4 at the end.
- Back-to-back: 3 words of 4 bytes pushed on consecutive cycles with s_valid held high.
  - Expect 12 contiguous bytes with m_last at bytes 4, 8 and 12.
  - Hold m_ready=0 for the first 8 cycles: s_ready must deassert once 2 words are queued behind the active word, and no word is lost.
- Reset mid-word: assert reset_n low during byte 2 of 4.
  - Expect m_valid=0, byte_count=0 and s_ready=0 immediately.
  - After release, no stale bytes are emitted and a new word streams correctly.
- Counter wrap: COUNT_W=4, 5 words of 4 bytes (20 bytes).
  - Expect byte_count to read 4'h4 after the last transfer (wraps past 15).
